// File: rtl/aq_gemac_rx_frame.sv
// Purpose : GMII receive framer. Strips preamble/SFD/FCS, streams the payload with sof/eof,
//           checks CRC-32 and frame length, and emits one status word per frame.
// Latency : payload byte i leaves one cycle after byte i+5 is sampled; status leaves with eof.
// Backpressure: none; the consumer must accept every o_rx_valid beat.
// Ports   : i_rx_clk/i_rst (sync, active-high); i_gmii_rxd/rxe/rxer from the PHY converter;
//           o_rx_data/valid/sof/eof payload stream; o_rx_stat_valid qualifies o_rx_len and
//           the crc/len/phy error flags (held between pulses); o_rx_good_cnt/o_rx_bad_cnt wrap.
module aq_gemac_rx_frame #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        i_rx_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_gmii_rxd,
  input  logic        i_gmii_rxe,
  input  logic        i_gmii_rxer,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_valid,
  output logic        o_rx_sof,
  output logic        o_rx_eof,
  output logic        o_rx_stat_valid,
  output logic [15:0] o_rx_len,
  output logic        o_rx_crc_err,
  output logic        o_rx_len_err,
  output logic        o_rx_phy_err,
  output logic [15:0] o_rx_good_cnt,
  output logic [15:0] o_rx_bad_cnt
);

  localparam logic [15:0] LP_MIN_LEN = 16'(MIN_LEN);
  localparam logic [15:0] LP_MAX_LEN = 16'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_END, S_DROP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_sfd;
  logic [7:0]  r_dly [5];
  logic [2:0]  r_fill;
  logic        r_sof_pend;
  logic [31:0] r_crc;
  logic [31:0] w_crc_rev;
  logic [15:0] r_len;
  logic        r_phy;
  logic        w_data_beat;
  logic        w_frame_end;
  logic        w_crc_bad;
  logic        w_len_bad;

  // Reflected CRC-32 (0x04C11DB7 reversed = 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  always_ff @(posedge i_rx_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // END evaluates its input exactly like IDLE so that a frame may begin on the
  // sample right after the single gap cycle.
  always_comb begin
    w_next = r_state;
    w_sfd  = 1'b0;
    case (r_state)
      S_IDLE, S_END, S_PRE: begin
        if (!i_gmii_rxe)                w_next = S_IDLE;
        else if (i_gmii_rxer)           w_next = S_DROP;
        else if (i_gmii_rxd == 8'hD5) begin
          w_next = S_DATA;
          w_sfd  = 1'b1;
        end
        else if (i_gmii_rxd == 8'h55)   w_next = S_PRE;
        else                            w_next = S_DROP;
      end
      S_DATA:  if (!i_gmii_rxe) w_next = S_END;
      S_DROP:  if (!i_gmii_rxe) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_data_beat = (r_state == S_DATA) && i_gmii_rxe;
  assign w_frame_end = (r_state == S_DATA) && !i_gmii_rxe;

  // The residue constant is quoted in normal bit order; the register is reflected.
  always_comb begin
    w_crc_rev = '0;
    for (int k = 0; k < 32; k++) w_crc_rev[k] = r_crc[31-k];
  end

  assign w_crc_bad = (w_crc_rev != 32'hC704DD7B);
  // Frames of 4 bytes or fewer carry no payload and are always a length error;
  // a saturated count means the real length is unknown and therefore illegal.
  assign w_len_bad = (r_len < LP_MIN_LEN) || (r_len > LP_MAX_LEN) ||
                     (r_len < 16'd5) || (r_len == 16'hFFFF);

  always_ff @(posedge i_rx_clk) begin
    if (i_rst) begin
      o_rx_data       <= '0;
      o_rx_valid      <= 1'b0;
      o_rx_sof        <= 1'b0;
      o_rx_eof        <= 1'b0;
      o_rx_stat_valid <= 1'b0;
      o_rx_len        <= '0;
      o_rx_crc_err    <= 1'b0;
      o_rx_len_err    <= 1'b0;
      o_rx_phy_err    <= 1'b0;
      o_rx_good_cnt   <= '0;
      o_rx_bad_cnt    <= '0;
      r_crc           <= 32'hFFFFFFFF;
      r_fill          <= '0;
      r_sof_pend      <= 1'b0;
      r_len           <= '0;
      r_phy           <= 1'b0;
      for (int k = 0; k < 5; k++) r_dly[k] <= '0;
    end
    else begin
      o_rx_valid      <= 1'b0;
      o_rx_sof        <= 1'b0;
      o_rx_eof        <= 1'b0;
      o_rx_stat_valid <= 1'b0;

      if (w_sfd) begin
        r_crc      <= 32'hFFFFFFFF;
        r_len      <= '0;
        r_fill     <= '0;
        r_phy      <= 1'b0;
        r_sof_pend <= 1'b1;
      end

      if (w_data_beat) begin
        r_dly[0] <= i_gmii_rxd;
        for (int k = 1; k < 5; k++) r_dly[k] <= r_dly[k-1];
        r_crc <= crc_byte(r_crc, i_gmii_rxd);
        if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
        if (i_gmii_rxer) r_phy <= 1'b1;
        // Once five bytes are held, each new byte pushes the oldest out.
        if (r_fill == 3'd5) begin
          o_rx_valid <= 1'b1;
          o_rx_data  <= r_dly[4];
          o_rx_sof   <= r_sof_pend;
          r_sof_pend <= 1'b0;
        end
        else begin
          r_fill <= r_fill + 3'd1;
        end
      end

      if (w_frame_end) begin
        // Oldest held byte is the last payload byte; the other four are the FCS.
        if (r_fill == 3'd5) begin
          o_rx_valid <= 1'b1;
          o_rx_data  <= r_dly[4];
          o_rx_sof   <= r_sof_pend;
          o_rx_eof   <= 1'b1;
        end
        r_sof_pend      <= 1'b0;
        r_fill          <= '0;
        o_rx_stat_valid <= 1'b1;
        o_rx_len        <= r_len;
        o_rx_crc_err    <= w_crc_bad;
        o_rx_len_err    <= w_len_bad;
        o_rx_phy_err    <= r_phy;
        if (w_crc_bad || w_len_bad || r_phy) o_rx_bad_cnt  <= o_rx_bad_cnt + 16'd1;
        else                                 o_rx_good_cnt <= o_rx_good_cnt + 16'd1;
      end
    end
  end

endmodule
